// File: rtl/ber_window_monitor_pkg.sv
// ============================================================================
// ber_pkg: shared types, default widths and saturating add for the BER window
// monitor.  Rev 1.0
// ============================================================================
`default_nettype none

package ber_pkg;

   localparam int BER_ERR_W = 13;
   localparam int BER_CNT_W = 16;
   localparam int SAT_W     = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Adds two unsigned values and clamps the sum to 2^w-1 (w <= SAT_W).
   function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                input logic [SAT_W-1:0] b,
                                                input int unsigned      w);
      logic [SAT_W:0] sum;
      logic [SAT_W:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = ({{SAT_W{1'b0}}, 1'b1} << w) - {{SAT_W{1'b0}}, 1'b1};
      return (sum > lim) ? lim[SAT_W-1:0] : sum[SAT_W-1:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/ber_window_monitor_if.sv
// ============================================================================
// ber_window_monitor_if: result valid/ready handshake bundle.  Rev 1.0
// ============================================================================
`default_nettype none

interface ber_window_monitor_if
   import ber_pkg::*;
#(
   parameter int ERR_W = BER_ERR_W,
   parameter int CNT_W = BER_CNT_W
);
   logic             res_valid;
   logic             res_ready;
   logic [ERR_W-1:0] res_errors;
   logic [CNT_W-1:0] res_bits;
   logic             res_alarm;
   logic [7:0]       res_index;

   modport master (output res_valid, res_errors, res_bits, res_alarm, res_index,
                   input  res_ready);
   modport slave  (input  res_valid, res_errors, res_bits, res_alarm, res_index,
                   output res_ready);
endinterface

`default_nettype wire

// File: rtl/ber_window_monitor_wrap_delta.sv
// ============================================================================
// wrap_delta: modular difference between a wrapping counter and its last
// sampled value.  Rev 1.0
// ============================================================================
`default_nettype none

module wrap_delta #(
   parameter int W = 16
) (
   input  wire logic         clock,
   input  wire logic         reset,
   input  wire logic         en,
   input  wire logic [W-1:0] cur,
   output logic      [W-1:0] delta
);
   logic [W-1:0] prev;

   always_ff @(posedge clock) begin
      if (reset) begin
         prev <= '0;
      end else if (en) begin
         prev <= cur;
      end
   end

   // Natural W-bit wrap of the subtraction gives the increment across rollover.
   assign delta = cur - prev;
endmodule

`default_nettype wire

// File: rtl/ber_window_monitor.sv
// ============================================================================
// ber_window_monitor: windowed errors/bits measurement with result handshake.
// Optional threshold alarm enabled by macro BER_ALARM_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module ber_window_monitor
   import ber_pkg::*;
#(
   parameter int ERR_W = BER_ERR_W,
   parameter int CNT_W = BER_CNT_W
) (
   input  wire logic             clock,
   input  wire logic             reset,
   input  wire logic             start,
   input  wire logic             stop,
   input  wire logic [CNT_W-1:0] win_bits,
   input  wire logic [ERR_W-1:0] err_thresh,
   input  wire logic [ERR_W-1:0] total_error_in,
   input  wire logic [CNT_W-1:0] count_in,
   ber_window_monitor_if.master  res,
   output logic                  overrun,
   output logic                  busy
);
   state_t           state, state_nx;
   logic [CNT_W-1:0] win_len, bit_acc, dc, bit_sum, res_bits_q;
   logic [ERR_W-1:0] err_acc, de, err_sum, res_err_q;
   logic [7:0]       index_q;
   logic             valid_q, arm_ok, track, win_close;

   assign arm_ok = (state == IDLE) && start && !stop && (win_bits != '0);
   assign track  = (state != IDLE);

   always_comb begin
      state_nx = state;
      if (stop) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (arm_ok) state_nx = ARM;
            ARM:     state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = IDLE;
         endcase
      end
   end

   wrap_delta #(.W(CNT_W)) u_bits (
      .clock(clock), .reset(reset), .en(track), .cur(count_in),       .delta(dc)
   );
   wrap_delta #(.W(ERR_W)) u_errs (
      .clock(clock), .reset(reset), .en(track), .cur(total_error_in), .delta(de)
   );

   assign bit_sum   = CNT_W'(sat_add(SAT_W'(bit_acc), SAT_W'(dc), CNT_W));
   assign err_sum   = ERR_W'(sat_add(SAT_W'(err_acc), SAT_W'(de), ERR_W));
   assign win_close = (state == RUN) && !stop && (bit_sum >= win_len);

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         win_len    <= '0;
         bit_acc    <= '0;
         err_acc    <= '0;
         res_bits_q <= '0;
         res_err_q  <= '0;
         index_q    <= '0;
         valid_q    <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state <= state_nx;
         busy  <= (state_nx != IDLE);
         if (arm_ok) win_len <= win_bits;

         // A closing window restarts at zero so the next one loses no bits.
         if (stop || (state == ARM) || win_close) begin
            bit_acc <= '0;
            err_acc <= '0;
         end else if (state == RUN) begin
            bit_acc <= bit_sum;
            err_acc <= err_sum;
         end

         if (!stop && (state == ARM)) begin
            index_q <= '0;
            overrun <= 1'b0;
         end

         if (win_close) begin
            res_bits_q <= bit_sum;
            res_err_q  <= err_sum;
            index_q    <= index_q + 8'd1;
            valid_q    <= 1'b1;
            if (valid_q && !res.res_ready) overrun <= 1'b1;
         end else if (valid_q && res.res_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

`ifdef BER_ALARM_EN
   logic [ERR_W-1:0] thresh;
   logic             alarm_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         thresh  <= '0;
         alarm_q <= 1'b0;
      end else begin
         if (arm_ok)    thresh  <= err_thresh;
         if (win_close) alarm_q <= (err_sum > thresh);
      end
   end

   assign res.res_alarm = alarm_q;
`else
   logic unused_thresh;
   assign unused_thresh = ^err_thresh;
   assign res.res_alarm = 1'b0;
`endif

   assign res.res_valid  = valid_q;
   assign res.res_errors = res_err_q;
   assign res.res_bits   = res_bits_q;
   assign res.res_index  = index_q;
endmodule

`default_nettype wire

// File: tb/tb_ber_window_monitor.sv
// ============================================================================
// tb_ber_window_monitor: randomized + directed scoreboard bench for the BER
// window monitor.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_ber_window_monitor;
   import ber_pkg::*;

   localparam int EW = BER_ERR_W;
   localparam int CW = BER_CNT_W;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          stop  = 1'b0;
   logic [CW-1:0] win_bits = '0;
   logic [EW-1:0] err_thresh = '0;
   logic [EW-1:0] total_error_in = '0;
   logic [CW-1:0] count_in = '0;
   logic          overrun, busy;

   ber_window_monitor_if #(.ERR_W(EW), .CNT_W(CW)) rif ();

   ber_window_monitor #(.ERR_W(EW), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .start(start), .stop(stop),
      .win_bits(win_bits), .err_thresh(err_thresh),
      .total_error_in(total_error_in), .count_in(count_in),
      .res(rif.master), .overrun(overrun), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      int bits;
      int errs;
      bit alarm;
      int index;
   } res_t;

   res_t exp_q[$];

   // Reference model: m_* is the state visible after the last edge, n_* after the next.
   int   m_phase, m_win, m_thr, m_tot_b, m_tot_e, m_prev_c, m_prev_e, m_index;
   bit   m_valid, m_overrun;
   res_t m_res;
   int   n_phase, n_win, n_thr, n_tot_b, n_tot_e, n_prev_c, n_prev_e, n_index;
   bit   n_valid, n_overrun, flush;
   res_t n_res;

   int checks = 0;
   int passes = 0;
   bit mon_en = 1'b0;
   int cum_c  = 0;
   int cum_e  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic commit();
      m_phase = n_phase; m_win = n_win; m_thr = n_thr;
      m_tot_b = n_tot_b; m_tot_e = n_tot_e; m_prev_c = n_prev_c; m_prev_e = n_prev_e;
      m_index = n_index; m_valid = n_valid; m_overrun = n_overrun; m_res = n_res;
      if (flush) begin
         exp_q.delete();
         flush = 1'b0;
      end
   endtask

   task automatic model_step(input bit r, input bit st, input bit sp, input int w,
                             input int t, input int e, input int c, input bit rdy);
      bit   closed;
      res_t nr;
      int   dcv, dev;
      n_phase = m_phase; n_win = m_win; n_thr = m_thr;
      n_tot_b = m_tot_b; n_tot_e = m_tot_e; n_prev_c = m_prev_c; n_prev_e = m_prev_e;
      n_index = m_index; n_valid = m_valid; n_overrun = m_overrun; n_res = m_res;
      closed  = 1'b0;
      nr      = '{0, 0, 1'b0, 0};
      if (r) begin
         n_phase = 0; n_win = 0; n_thr = 0; n_tot_b = 0; n_tot_e = 0;
         n_prev_c = 0; n_prev_e = 0; n_index = 0; n_valid = 0; n_overrun = 0;
         n_res = '{0, 0, 1'b0, 0};
         flush = 1'b1;
         return;
      end
      if (sp) begin
         n_phase = 0; n_tot_b = 0; n_tot_e = 0;
      end else if (m_phase == 0) begin
         if (st && w != 0) begin
            n_phase = 1; n_win = w; n_thr = t;
         end
      end else if (m_phase == 1) begin
         n_prev_c = c; n_prev_e = e; n_tot_b = 0; n_tot_e = 0;
         n_index = 0; n_overrun = 0; n_phase = 2;
      end else begin
         dcv = (c - m_prev_c) & 32'hFFFF;
         dev = (e - m_prev_e) & 32'h1FFF;
         n_prev_c = c; n_prev_e = e;
         n_tot_b = m_tot_b + dcv;
         n_tot_e = m_tot_e + dev;
         if (n_tot_b >= m_win) begin
            closed   = 1'b1;
            nr.bits  = min_i(n_tot_b, 65535);
            nr.errs  = min_i(n_tot_e, 8191);
`ifdef BER_ALARM_EN
            nr.alarm = (nr.errs > m_thr);
`else
            nr.alarm = 1'b0;
`endif
            nr.index = (m_index + 1) % 256;
            n_index  = nr.index;
            n_tot_b  = 0; n_tot_e = 0;
         end
      end
      if (closed) begin
         if (m_valid && !rdy) begin
            n_overrun = 1'b1;
            if (exp_q.size() > 0) exp_q[exp_q.size()-1] = nr;
            else exp_q.push_back(nr);
         end else begin
            exp_q.push_back(nr);
         end
         n_valid = 1'b1;
         n_res   = nr;
      end else if (m_valid && rdy) begin
         n_valid = 1'b0;
      end
   endtask

   task automatic cyc(input bit r, input bit st, input bit sp, input int w, input int t,
                      input int de, input int dc, input bit rdy);
      @(posedge clock);
      #1;
      commit();
      cum_c = (cum_c + dc) & 32'hFFFF;
      cum_e = (cum_e + de) & 32'h1FFF;
      reset = r; start = st; stop = sp;
      win_bits = CW'(w); err_thresh = EW'(t);
      count_in = CW'(cum_c); total_error_in = EW'(cum_e);
      rif.res_ready = rdy;
      model_step(r, st, sp, w, t, cum_e, cum_c, rdy);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   // Monitor: per-cycle state compare plus queue pop on each accepted result.
   always @(negedge clock) begin
      if (mon_en) begin
         res_t p;
         check("busy",       busy,           m_phase != 0);
         check("res_valid",  rif.res_valid,  m_valid);
         check("overrun",    overrun,        m_overrun);
         check("res_index",  rif.res_index,  m_index);
         check("res_bits",   rif.res_bits,   m_res.bits);
         check("res_errors", rif.res_errors, m_res.errs);
         check("res_alarm",  rif.res_alarm,  m_res.alarm);
         if (rif.res_valid && rif.res_ready) begin
            if (exp_q.size() == 0) begin
               check("sb_empty", 1, 0);
            end else begin
               p = exp_q.pop_front();
               check("sb_bits",   rif.res_bits,   p.bits);
               check("sb_errors", rif.res_errors, p.errs);
               check("sb_alarm",  rif.res_alarm,  p.alarm);
               check("sb_index",  rif.res_index,  p.index);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rif.res_ready = 1'b0;
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      mon_en = 1'b1;
      cyc(1, 0, 0, 0, 0, 0, 0, 0);

      // start with a zero-length window is ignored
      cyc(0, 1, 0, 0, 3, 0, 0, 1);
      idle(3);

      // basic window: 100 bits, one error every tenth bit
      cyc(0, 1, 0, 100, 5, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 110; k++) cyc(0, 0, 0, 0, 0, (k % 10 == 9) ? 1 : 0, 1, 1);
      cyc(0, 0, 1, 0, 0, 0, 0, 1);

      // counters wrap inside the window
      cum_c = 65530; cum_e = 8190;
      cyc(0, 1, 0, 20, 5, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 25; k++) cyc(0, 0, 0, 0, 0, (k % 3 == 0) ? 1 : 0, 1, 1);
      cyc(0, 0, 1, 0, 0, 0, 0, 1);

      // overrun: two windows with the consumer stalled, then accept
      cyc(0, 1, 0, 8, 5, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 18; k++) cyc(0, 0, 0, 0, 0, k % 2, 1, 0);
      for (int k = 0; k < 4; k++)  cyc(0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 0, 0, 1);

      // alarm threshold 5: windows of 6 then 5 errors
      cyc(0, 1, 0, 10, 5, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 20; k++)
         cyc(0, 0, 0, 0, 0, (k < 6 || (k >= 10 && k < 15)) ? 1 : 0, 1, 1);
      cyc(0, 0, 1, 0, 0, 0, 0, 1);

      // stop and start together while running
      cyc(0, 1, 0, 50, 5, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 0, 1, 1, 1);
      cyc(0, 1, 1, 50, 5, 0, 1, 1);
      idle(2);

      // reset mid-window with a result pending
      cyc(0, 1, 0, 4, 5, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 0, 1, 1, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      idle(2);

      // error saturation in a maximum-length window
      cyc(0, 1, 0, 65535, 5, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 70; k++) cyc(0, 0, 0, 0, 0, 150, 1000, 1);
      cyc(0, 0, 1, 0, 0, 0, 0, 1);

      // one close per cycle
      cyc(0, 1, 0, 1, 1, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 30; k++)
         cyc(0, 0, 0, 0, 0, $urandom_range(0, 2), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      cyc(0, 0, 1, 0, 0, 0, 0, 1);

      // randomized traffic and control
      for (int k = 0; k < 600; k++) begin
         bit r, st, sp, rdy;
         int w, t, dcv, dev;
         r   = ($urandom_range(0, 199) == 0);
         st  = ($urandom_range(0, 19) == 0);
         sp  = ($urandom_range(0, 39) == 0);
         w   = $urandom_range(0, 40);
         t   = $urandom_range(0, 6);
         dcv = ($urandom_range(0, 49) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 4);
         dev = ($urandom_range(0, 49) == 0) ? $urandom_range(0, 8191)  : $urandom_range(0, 2);
         rdy = ($urandom_range(0, 3) != 0);
         cyc(r, st, sp, w, t, dev, dcv, rdy);
      end
      idle(3);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

`default_nettype wire
